// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: ALU and MDU write sources in, register-file write port
// and pipeline status out.
interface wb_arbiter_if #(
    parameter int DEPTH = 4,
    parameter int DW    = 32
);
    logic                       alu_valid;
    logic [4:0]                 alu_waddr;
    logic [DW-1:0]              alu_wdata;
    logic                       mdu_valid;
    logic                       mdu_ready;
    logic [4:0]                 mdu_waddr;
    logic [DW-1:0]              mdu_wdata;
    logic                       we;
    logic [4:0]                 waddr;
    logic [DW-1:0]              wdata;
    logic [31:0]                busy_mask;
    logic [$clog2(DEPTH):0]     fifo_count;

    modport master (
        output alu_valid, alu_waddr, alu_wdata, mdu_valid, mdu_waddr, mdu_wdata,
        input  mdu_ready, we, waddr, wdata, busy_mask, fifo_count
    );

    modport slave (
        input  alu_valid, alu_waddr, alu_wdata, mdu_valid, mdu_waddr, mdu_wdata,
        output mdu_ready, we, waddr, wdata, busy_mask, fifo_count
    );
endinterface

// File: rtl/wb_arbiter.sv
// Merges the ALU (priority) and buffered MDU write streams into one register-file
// write port, dropping r0 writes and squashing queued writes overtaken by the ALU.
module wb_arbiter #(
    parameter int DEPTH = 4,
    parameter int DW    = 32
) (
    input logic          clk,
    input logic          rst,
    wb_arbiter_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [4:0]       addr_q [DEPTH];
    logic [4:0]       addr_d [DEPTH];
    logic [DW-1:0]    data_q [DEPTH];
    logic [DW-1:0]    data_d [DEPTH];
    logic [DEPTH-1:0] kill_q, kill_d;
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             we_q, we_d;
    logic [4:0]       waddr_q, waddr_d;
    logic [DW-1:0]    wdata_q, wdata_d;
    logic [31:0]      busy;

    logic alu_alive;
    logic mdu_ready;
    logic push;
    logic pop;

    assign alu_alive = bus.alu_valid && (bus.alu_waddr != '0);
    assign mdu_ready = cnt_q < CW'(DEPTH);
    assign push      = bus.mdu_valid && mdu_ready && (bus.mdu_waddr != '0);
    assign pop       = !alu_alive && (cnt_q != '0);

    always_comb begin
        addr_d  = addr_q;
        data_d  = data_q;
        kill_d  = kill_q;
        vld_d   = vld_q;
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;

        if (alu_alive) begin
            we_d    = 1'b1;
            waddr_d = bus.alu_waddr;
            wdata_d = bus.alu_wdata;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (addr_q[i] == bus.alu_waddr) begin
                    kill_d[i] = 1'b1;
                end
            end
        end else if (pop) begin
            if (!kill_q[rptr_q]) begin
                we_d    = 1'b1;
                waddr_d = addr_q[rptr_q];
                wdata_d = data_q[rptr_q];
            end
            vld_d[rptr_q] = 1'b0;
            rptr_d        = rptr_q + AW'(1);
        end

        // The tail slot is free whenever push is allowed, so it never collides with the popped head.
        if (push) begin
            addr_d[wptr_q] = bus.mdu_waddr;
            data_d[wptr_q] = bus.mdu_wdata;
            kill_d[wptr_q] = alu_alive && (bus.mdu_waddr == bus.alu_waddr);
            vld_d[wptr_q]  = 1'b1;
            wptr_d         = wptr_q + AW'(1);
        end

        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_comb begin
        busy = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && !kill_q[i]) begin
                busy = busy | (32'd1 << addr_q[i]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
            kill_q  <= '0;
            vld_q   <= '0;
            rptr_q  <= '0;
            wptr_q  <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            addr_q  <= addr_d;
            data_q  <= data_d;
            kill_q  <= kill_d;
            vld_q   <= vld_d;
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign bus.mdu_ready  = mdu_ready;
    assign bus.we         = we_q;
    assign bus.waddr      = waddr_q;
    assign bus.wdata      = wdata_q;
    assign bus.busy_mask  = busy;
    assign bus.fifo_count = cnt_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: a queue-based model predicts the post-edge
// state, and a negedge monitor compares the DUT against each prediction.
module tb_wb_arbiter;
    localparam int DEPTH = 4;
    localparam int DW    = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    wb_arbiter_if #(.DEPTH(DEPTH), .DW(DW)) bus ();
    wb_arbiter #(.DEPTH(DEPTH), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        bit          kill;
    } ent_t;

    typedef struct {
        bit          we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        int          count;
        logic [31:0] busy;
        bit          ready;
    } st_t;

    ent_t        mq[$];
    st_t         sq[$];
    int          checks = 0;
    int          errors = 0;
    logic [4:0]  m_waddr = '0;
    logic [31:0] m_wdata = '0;
    bit          mdu_acc;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endfunction

    // Reference model: retire one write per edge, ALU first, else the FIFO head.
    task automatic step();
        bit   alive, ready, acc, we;
        ent_t e, h;
        st_t  s;
        alive = bus.alu_valid && (bus.alu_waddr != 5'd0);
        ready = mq.size() < DEPTH;
        acc   = bus.mdu_valid && ready;
        we    = 1'b0;
        if (alive) begin
            we      = 1'b1;
            m_waddr = bus.alu_waddr;
            m_wdata = bus.alu_wdata;
            foreach (mq[i]) if (mq[i].addr == bus.alu_waddr) mq[i].kill = 1'b1;
        end else if (mq.size() > 0) begin
            h = mq.pop_front();
            if (!h.kill) begin
                we      = 1'b1;
                m_waddr = h.addr;
                m_wdata = h.data;
            end
        end
        if (acc && bus.mdu_waddr != 5'd0) begin
            e.addr = bus.mdu_waddr;
            e.data = bus.mdu_wdata;
            e.kill = alive && (bus.mdu_waddr == bus.alu_waddr);
            mq.push_back(e);
        end
        mdu_acc = acc;
        s.we    = we;
        s.waddr = m_waddr;
        s.wdata = m_wdata;
        s.count = mq.size();
        s.busy  = '0;
        foreach (mq[i]) if (!mq[i].kill) s.busy[mq[i].addr] = 1'b1;
        s.ready = mq.size() < DEPTH;
        @(posedge clk);
        sq.push_back(s);
        #1;
    endtask

    task automatic drive(bit av, int aa, int ad, bit mv, int ma, int md);
        bus.alu_valid = av;
        bus.alu_waddr = 5'(aa);
        bus.alu_wdata = 32'(ad);
        bus.mdu_valid = mv;
        bus.mdu_waddr = 5'(ma);
        bus.mdu_wdata = 32'(md);
        step();
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0);
    endtask

    initial begin : monitor
        st_t s;
        forever begin
            @(negedge clk);
            if (sq.size() > 0) begin
                s = sq.pop_front();
                chk("we", 64'(bus.we), 64'(s.we));
                chk("waddr", 64'(bus.waddr), 64'(s.waddr));
                chk("wdata", 64'(bus.wdata), 64'(s.wdata));
                chk("fifo_count", 64'(bus.fifo_count), 64'(s.count));
                chk("busy_mask", 64'(bus.busy_mask), 64'(s.busy));
                chk("mdu_ready", 64'(bus.mdu_ready), 64'(s.ready));
            end
        end
    end

    initial begin : stim
        bit pend;
        int pa, pd, n;
        bus.alu_valid = 1'b0; bus.alu_waddr = '0; bus.alu_wdata = '0;
        bus.mdu_valid = 1'b0; bus.mdu_waddr = '0; bus.mdu_wdata = '0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_we", 64'(bus.we), 64'd0);
        chk("reset_waddr", 64'(bus.waddr), 64'd0);
        chk("reset_wdata", 64'(bus.wdata), 64'd0);
        chk("reset_ready", 64'(bus.mdu_ready), 64'd1);
        rst = 1'b1;
        idle(2);

        // Priority: ALU r3 and MDU r4 in the same cycle
        drive(1, 3, 'h11, 1, 4, 'h22);
        idle(3);

        // Full / backpressure behind a continuous ALU stream on r1
        for (int k = 5; k <= 8; k++) drive(1, 1, 'h100 + k, 1, k, 'h50 + k);
        drive(1, 1, 'h200, 1, 10, 'h55);
        drive(1, 1, 'h201, 1, 10, 'h55);
        n = 0;
        do begin
            drive(0, 0, 0, 1, 10, 'h55);
            n++;
        end while (!mdu_acc && n < 10);
        chk("held_push_accepted", 64'(mdu_acc), 64'd1);
        idle(3);

        // Squash: r9 queued behind an ALU stream, then ALU writes r9
        drive(1, 1, 'h1, 1, 9, 'hAA);
        drive(1, 9, 'hBB, 0, 0, 0);
        idle(3);

        // Same-cycle push and squash on r7
        drive(1, 7, 'h1, 1, 7, 'h2);
        idle(3);

        // Register zero on both paths
        drive(1, 0, 'h5, 1, 0, 'h6);
        chk("r0_handshake", 64'(mdu_acc), 64'd1);
        idle(2);

        // Asynchronous reset with three entries queued
        drive(1, 1, 'h31, 1, 5, 'h41);
        drive(1, 2, 'h32, 1, 6, 'h42);
        drive(1, 3, 'h33, 1, 7, 'h43);
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("mid_reset_we", 64'(bus.we), 64'd0);
        chk("mid_reset_count", 64'(bus.fifo_count), 64'd0);
        chk("mid_reset_busy", 64'(bus.busy_mask), 64'd0);
        chk("mid_reset_ready", 64'(bus.mdu_ready), 64'd1);
        mq.delete();
        m_waddr = '0;
        m_wdata = '0;
        bus.alu_valid = 1'b0;
        bus.mdu_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        idle(4);

        // Randomized traffic with a source that holds its request until accepted
        pend = 1'b0; pa = 0; pd = 0;
        for (int c = 0; c < 400; c++) begin
            if (!pend && $urandom_range(1, 0) == 1) begin
                pend = 1'b1;
                pa   = $urandom_range(7, 0);
                pd   = int'($urandom);
            end
            drive(($urandom_range(9, 0) < 6), $urandom_range(7, 0), int'($urandom),
                  pend, pa, pd);
            if (mdu_acc) pend = 1'b0;
        end
        idle(DEPTH + 2);

        n = 0;
        while (sq.size() > 0 && n < 5) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", 64'(sq.size()), 64'd0);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
